// File: rtl/wb_host_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_host_pkg
// Brief  : Command types and opcode-word layout for the Wishbone host sequencer.
// Rev    : 1.0
// ============================================================================
package wb_host_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_READ  = 2'b01,
        CMD_OP    = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_kind_e;

    typedef struct packed {
        cmd_kind_e   kind;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam int unsigned c_op_code_lsb  = 0;
    localparam int unsigned c_op_code_w    = 2;
    localparam int unsigned c_opnd_a_lsb   = 2;
    localparam int unsigned c_opnd_b_lsb   = 11;
    localparam int unsigned c_opnd_c_lsb   = 20;
    localparam int unsigned c_opnd_w       = 9;
    localparam int unsigned c_op_start_bit = 31;
    localparam logic [3:0]  c_sel_all      = 4'b1111;

    // Start flag in bit 31, opcode/operand payload passed through, bits between forced low.
    function automatic logic [31:0] op_word(input logic [31:0] data, input int unsigned payload_w);
        logic [31:0] mask;
        mask = (32'd1 << payload_w) - 32'd1;
        return (32'd1 << c_op_start_bit) | (data & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_host_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : wb_host_sequencer_if
// Brief  : Command, response and Wishbone master signals of the host sequencer.
// Rev    : 1.0
// ============================================================================
interface wb_host_sequencer_if;

    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_kind_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_kind_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    logic        busy_o;

    // Sequencer side.
    modport master (
        input  cmd_valid_i, cmd_kind_i, cmd_addr_i, cmd_data_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_kind_o, rsp_data_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output busy_o
    );

    // Environment side: command producer, response consumer and bus slave.
    modport slave (
        output cmd_valid_i, cmd_kind_i, cmd_addr_i, cmd_data_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_kind_o, rsp_data_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  busy_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_host_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_host_cmd_fifo
// Brief  : Synchronous command FIFO with registered full/empty flags.
// Rev    : 1.0
// ============================================================================
module wb_host_cmd_fifo
    import wb_host_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned      c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_depth = DEPTH[c_aw:0];

    cmd_t            r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic [c_aw:0]   w_count_nxt;
    logic            w_push;
    logic            w_pop;

    // Full refuses a push even when a pop happens in the same cycle.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/wb_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module : wb_host_sequencer
// Brief  : Wishbone classic master running one bus cycle per buffered command.
// Rev    : 1.0
// ============================================================================
module wb_host_sequencer
    import wb_host_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] OPCODE_ADDR    = 32'h3000_0000,
    parameter int unsigned OPND_WIDTH     = 9
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    wb_host_sequencer_if.master bus
);

    localparam int unsigned          c_tmr_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmr_w-1:0]   c_timeout   = TIMEOUT_CYCLES[c_tmr_w-1:0];
    localparam int unsigned          c_payload_w = c_op_code_w + 3 * OPND_WIDTH;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_cyc;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic [1:0]         r_kind;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_kind;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;

    cmd_t               w_cmd_in;
    cmd_t               w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [31:0]        w_nxt_adr;
    logic [31:0]        w_nxt_dat;
    logic               w_nxt_we;
    logic [c_tmr_w-1:0] w_timer_inc;

    assign w_cmd_in = '{kind: cmd_kind_e'(bus.cmd_kind_i), addr: bus.cmd_addr_i, data: bus.cmd_data_i};
    assign w_pop    = (r_state == c_st_idle) & ~w_empty;

    wb_host_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_push  (bus.cmd_valid_i),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Reserved kind falls through to READ semantics.
    always_comb begin
        w_nxt_adr = w_head.addr;
        w_nxt_dat = w_head.data;
        w_nxt_we  = 1'b1;
        case (w_head.kind)
            CMD_WRITE: ;
            CMD_OP: begin
                w_nxt_adr = OPCODE_ADDR;
                w_nxt_dat = op_word(w_head.data, c_payload_w);
            end
            default: begin
                w_nxt_dat = '0;
                w_nxt_we  = 1'b0;
            end
        endcase
    end

    assign w_timer_inc = r_timer + 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= c_st_idle;
            r_timer     <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_kind      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_kind  <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        r_adr   <= w_nxt_adr;
                        r_dat   <= w_nxt_dat;
                        r_we    <= w_nxt_we;
                        r_kind  <= w_head.kind;
                        r_sel   <= c_sel_all;
                        r_cyc   <= 1'b1;
                        r_timer <= '0;
                        r_state <= c_st_bus;
                    end
                end
                c_st_bus: begin
                    r_timer <= w_timer_inc;
                    if (bus.wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_sel       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_kind  <= r_kind;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= r_we ? 32'h0 : bus.wbm_dat_i;
                        r_state     <= c_st_resp;
                    end else if (w_timer_inc == c_timeout) begin
                        r_cyc       <= 1'b0;
                        r_sel       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_kind  <= r_kind;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.cmd_ready_o = ~w_full;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_cyc;
    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_sel_o   = r_sel;
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_dat;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_kind_o  = r_rsp_kind;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.busy_o      = (r_state != c_st_idle) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_host_sequencer
// Brief  : Directed bench with a transaction-level model and bus slave for wb_host_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_wb_host_sequencer;

    localparam int unsigned TIMEOUT  = 64;
    localparam logic [31:0] OPC_ADDR = 32'h3000_0000;

    typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; logic err; } bus_exp_t;
    typedef struct { logic [1:0] kind; logic [31:0] data; logic err; } rsp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_host_sequencer_if bus ();

    wb_host_sequencer #(
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .OPCODE_ADDR    (OPC_ADDR),
        .OPND_WIDTH     (9)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bus_exp_t    exp_bus [$];
    rsp_exp_t    exp_rsp [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    bit          slave_noack;
    int          ack_delay;
    int          scnt;

    bus_exp_t    cur_bus;
    logic        prev_cyc, prev_hold, prev_err, seen_fall;
    logic [1:0]  prev_kind;
    logic [31:0] prev_data;
    int          cyc_len, gap, min_gap, cycle_no, accept_no, rise_no, rsp_count;
    logic [31:0] last_adr, last_dat, last_rsp_data;
    logic [3:0]  last_sel;
    logic [1:0]  last_rsp_kind;
    logic        last_we, last_rsp_err;
    int          last_cyc_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // What the bus cycle and response must look like, from command kind and slave behaviour.
    function automatic void model_accept(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
        bus_exp_t b;
        rsp_exp_t r;
        case (kind)
            2'b00:   begin b.adr = addr;     b.dat = data; b.we = 1'b1; end
            2'b10:   begin b.adr = OPC_ADDR; b.dat = 32'h8000_0000 | (data & 32'h1FFF_FFFF); b.we = 1'b1; end
            default: begin b.adr = addr;     b.dat = 32'h0; b.we = 1'b0; end
        endcase
        b.err  = slave_noack;
        r.kind = kind;
        r.err  = slave_noack;
        r.data = 32'h0;
        if (!slave_noack) begin
            if (b.we) ref_mem[b.adr] = b.dat;
            else      r.data = ref_mem.exists(b.adr) ? ref_mem[b.adr] : 32'h0;
        end
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endfunction

    // Bus slave: ack after ack_delay+1 cycles of cyc/stb, single-cycle ack.
    initial begin
        scnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || bus.wbm_ack_i) begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_dat_i = 32'hDEAD_BEEF;
                scnt = 0;
            end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !slave_noack) begin
                if (scnt >= ack_delay) begin
                    bus.wbm_ack_i = 1'b1;
                    if (bus.wbm_we_o) slv_mem[bus.wbm_adr_o] = bus.wbm_dat_o;
                    else bus.wbm_dat_i = slv_mem.exists(bus.wbm_adr_o) ? slv_mem[bus.wbm_adr_o] : 32'h0;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Compare process.
    initial begin
        prev_cyc = 0; prev_hold = 0; seen_fall = 0; cyc_len = 0; gap = 0;
        min_gap = 1000; cycle_no = 0; accept_no = 0; rise_no = 0; rsp_count = 0;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (!rst_n) begin
                prev_cyc = 0; prev_hold = 0; cyc_len = 0; gap = 0; seen_fall = 0;
            end else begin
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    model_accept(bus.cmd_kind_i, bus.cmd_addr_i, bus.cmd_data_i);
                    accept_no = cycle_no;
                end
                check("stb_eq_cyc", 32'(bus.wbm_stb_o), 32'(bus.wbm_cyc_o));
                check("sel", 32'(bus.wbm_sel_o), bus.wbm_cyc_o ? 32'hF : 32'h0);
                if (bus.wbm_cyc_o && !prev_cyc) begin
                    rise_no = cycle_no;
                    if (seen_fall && gap < min_gap) min_gap = gap;
                    last_adr = bus.wbm_adr_o; last_dat = bus.wbm_dat_o;
                    last_we  = bus.wbm_we_o;  last_sel = bus.wbm_sel_o;
                    if (exp_bus.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_bus_cycle: got adr %h expected no cycle", bus.wbm_adr_o);
                        cur_bus = '{adr: 32'h0, dat: 32'h0, we: 1'b0, err: 1'b0};
                    end else begin
                        cur_bus = exp_bus.pop_front();
                        check("bus_adr", bus.wbm_adr_o, cur_bus.adr);
                        check("bus_dat", bus.wbm_dat_o, cur_bus.dat);
                        check("bus_we", 32'(bus.wbm_we_o), 32'(cur_bus.we));
                    end
                    cyc_len = 0;
                end
                if (bus.wbm_cyc_o) cyc_len++;
                else gap++;
                if (!bus.wbm_cyc_o && prev_cyc) begin
                    last_cyc_len = cyc_len;
                    check("cyc_len", 32'(cyc_len), cur_bus.err ? 32'(TIMEOUT) : 32'(ack_delay + 1));
                    check("rsp_with_drop", 32'(bus.rsp_valid_o), 32'd1);
                    seen_fall = 1; gap = 1;
                end
                if (prev_hold) begin
                    check("rsp_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
                    check("rsp_hold_kind", 32'(bus.rsp_kind_o), 32'(prev_kind));
                    check("rsp_hold_data", bus.rsp_data_o, prev_data);
                    check("rsp_hold_err", 32'(bus.rsp_err_o), 32'(prev_err));
                end
                if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                    rsp_count++;
                    last_rsp_kind = bus.rsp_kind_o; last_rsp_data = bus.rsp_data_o; last_rsp_err = bus.rsp_err_o;
                    if (exp_rsp.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_rsp: got kind %h data %h expected no response", bus.rsp_kind_o, bus.rsp_data_o);
                    end else begin
                        rsp_exp_t r;
                        r = exp_rsp.pop_front();
                        check("rsp_kind", 32'(bus.rsp_kind_o), 32'(r.kind));
                        check("rsp_data", bus.rsp_data_o, r.data);
                        check("rsp_err", 32'(bus.rsp_err_o), 32'(r.err));
                    end
                end
                prev_hold = bus.rsp_valid_o && !bus.rsp_ready_i;
                prev_kind = bus.rsp_kind_o; prev_data = bus.rsp_data_o; prev_err = bus.rsp_err_o;
                prev_cyc  = bus.wbm_cyc_o;
            end
        end
    end

    task automatic send(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
        int  t  = 0;
        bit  ok = 0;
        bus.cmd_kind_i = k; bus.cmd_addr_i = a; bus.cmd_data_i = d; bus.cmd_valid_i = 1'b1;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (bus.cmd_ready_o) ok = 1;
            @(posedge clk); #1;
            t++;
        end
        bus.cmd_valid_i = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL send_accept: got no acceptance expected cmd_ready within 200 cycles");
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((bus.busy_o || bus.rsp_valid_o || exp_rsp.size() != 0) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_drained"}, 32'(t < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc0;
        bus.cmd_valid_i = 0; bus.cmd_kind_i = 0; bus.cmd_addr_i = 0; bus.cmd_data_i = 0;
        bus.rsp_ready_i = 1; bus.wbm_ack_i = 0; bus.wbm_dat_i = 32'hDEAD_BEEF;
        slave_noack = 0; ack_delay = 2;
        slv_mem[32'h3000_00cc] = 32'd30;
        ref_mem[32'h3000_00cc] = 32'd30;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_adr", bus.wbm_adr_o, 32'd0);
        check("rst_rsp_data", bus.rsp_data_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) @(posedge clk); #1;

        // 1: WRITE, slave ack after 2 cycles
        send(2'b00, 32'h3000_0004, 32'd10);
        wait_drain("t1", 50);
        check("t1_first_cyc_latency", 32'(rise_no - accept_no), 32'd2);
        check("t1_adr", last_adr, 32'h3000_0004);
        check("t1_dat", last_dat, 32'd10);
        check("t1_we", 32'(last_we), 32'd1);
        check("t1_sel", 32'(last_sel), 32'hF);
        check("t1_rsp_err", 32'(last_rsp_err), 32'd0);
        check("t1_rsp_data", last_rsp_data, 32'd0);

        // 2: READ returns 30
        send(2'b01, 32'h3000_00cc, 32'hFFFF_FFFF);
        wait_drain("t2", 50);
        check("t2_we", 32'(last_we), 32'd0);
        check("t2_dat", last_dat, 32'd0);
        check("t2_rsp_kind", 32'(last_rsp_kind), 32'd1);
        check("t2_rsp_data", last_rsp_data, 32'd30);

        // 3: OP op=2 a=0 b=100 c=50, with junk in bits 31:29
        send(2'b10, 32'h1234_5678, 32'hE000_0000 | 32'd2 | (32'd0 << 2) | (32'd100 << 11) | (32'd50 << 20));
        wait_drain("t3", 50);
        check("t3_adr", last_adr, 32'h3000_0000);
        check("t3_dat", last_dat, 32'h8323_2002);
        check("t3_rsp_data", last_rsp_data, 32'd0);

        // 4: no ack -> timeout after TIMEOUT cycles, then the next command proceeds
        slave_noack = 1;
        send(2'b00, 32'h3000_0008, 32'h55);
        wait_drain("t4", 200);
        check("t4_cyc_len", 32'(last_cyc_len), 32'd64);
        check("t4_rsp_err", 32'(last_rsp_err), 32'd1);
        check("t4_rsp_data", last_rsp_data, 32'd0);
        slave_noack = 0;
        send(2'b01, 32'h3000_0004, 32'h0);
        wait_drain("t4b", 50);
        check("t4_next_err", 32'(last_rsp_err), 32'd0);
        check("t4_next_data", last_rsp_data, 32'd10);
        // Stray ack while idle must not start anything
        @(negedge clk); bus.wbm_ack_i = 1;
        repeat (4) @(posedge clk); #1;
        check("t4_stray_busy", 32'(bus.busy_o), 32'd0);
        check("t4_stray_rsp", 32'(bus.rsp_valid_o), 32'd0);

        // 5: responses blocked, FIFO fills, then 5 responses drain in order
        bus.rsp_ready_i = 0;
        rc0 = rsp_count;
        min_gap = 1000;
        send(2'b00, 32'h3000_0010, 32'h11);
        send(2'b00, 32'h3000_0014, 32'h22);
        send(2'b10, 32'h0, 32'h0000_0401);
        send(2'b01, 32'h3000_0010, 32'h0);
        send(2'b11, 32'h3000_0014, 32'h0);
        bus.cmd_kind_i = 2'b00; bus.cmd_addr_i = 32'h3000_0018; bus.cmd_data_i = 32'h66;
        bus.cmd_valid_i = 1;
        repeat (6) begin
            @(negedge clk);
            check("t5_full_ready", 32'(bus.cmd_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        bus.cmd_valid_i = 0;
        check("t5_held_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("t5_held_kind", 32'(bus.rsp_kind_o), 32'd0);
        bus.rsp_ready_i = 1;
        wait_drain("t5", 200);
        check("t5_rsp_count", 32'(rsp_count - rc0), 32'd5);
        check("t5_min_gap_ge1", 32'(min_gap >= 1), 32'd1);
        check("t5_last_kind", 32'(last_rsp_kind), 32'd3);
        check("t5_last_data", last_rsp_data, 32'h22);

        // 6: async reset during BUS drops everything, queued command lost
        slave_noack = 1;
        send(2'b00, 32'h3000_0020, 32'h77);
        send(2'b00, 32'h3000_0024, 32'h88);
        begin
            int t = 0;
            while (!bus.wbm_cyc_o && t < 20) begin @(posedge clk); #1; t++; end
            check("t6_in_bus", 32'(bus.wbm_cyc_o), 32'd1);
        end
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("t6_cyc_async", 32'(bus.wbm_cyc_o), 32'd0);
        check("t6_stb_async", 32'(bus.wbm_stb_o), 32'd0);
        check("t6_rsp_async", 32'(bus.rsp_valid_o), 32'd0);
        exp_bus.delete();
        exp_rsp.delete();
        slave_noack = 0;
        repeat (2) @(negedge clk);
        check("t6_busy_in_rst", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("t6_ready_after", 32'(bus.cmd_ready_o), 32'd1);
        check("t6_busy_after", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        send(2'b01, 32'h3000_0004, 32'h0);
        wait_drain("t6", 50);
        check("t6_next_data", last_rsp_data, 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
